// File: rtl/dm_tb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dm_tb_pkg : RV32I instruction encoders used to build boot stubs. Rev 1.0
// ---------------------------------------------------------------------------
package dm_tb_pkg;

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, OPC_LUI};
   endfunction

   function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, OPC_JALR};
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, OPC_OPIMM};
   endfunction

   // Canonical nop is addi x0,x0,0.
   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/boot_rom_obi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boot_rom_obi : OBI read-only boot stub (lui/jalr to EntryAddr). Rev 1.0
// ---------------------------------------------------------------------------
module boot_rom_obi
   import dm_tb_pkg::*;
#(
   parameter logic [31:0] BaseAddr   = 32'h1A00_0000,
   parameter logic [31:0] EntryAddr  = 32'h1C00_0080,
   parameter int unsigned RomSize    = 4,
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned WaitCycles = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [31:0]          addr_i,
   output logic                 gnt_o,
   output logic                 rvalid_o,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 err_o
);

   localparam int unsigned SlotsPerWord = DataWidth / 32;
   localparam int unsigned NumWords     = (RomSize + SlotsPerWord - 1) / SlotsPerWord;
   localparam int unsigned ByteShift    = $clog2(DataWidth / 8);
   localparam int unsigned IdxW         = (NumWords > 1) ? $clog2(NumWords) : 1;
   localparam logic [32:0] RomBytes     = 33'(NumWords) << ByteShift;
   localparam logic [32:0] EndAddr      = {1'b0, BaseAddr} + RomBytes;

   // jalr sign-extends its immediate, so bump hi when bit 11 of the target is set.
   localparam logic [19:0] Hi       = EntryAddr[31:12] + 20'(EntryAddr[11]);
   localparam logic [31:0] SlotLui  = lui(5'd1, Hi);
   localparam logic [31:0] SlotJalr = jalr(5'd0, 5'd1, EntryAddr[11:0]);

   typedef logic [NumWords-1:0][DataWidth-1:0] rom_t;

   function automatic logic [31:0] slot_val(input int unsigned s);
      if (s == 0) return SlotLui;
      if (s == 1) return SlotJalr;
      return NOP;
   endfunction

   function automatic rom_t build_rom();
      rom_t r;
      r = '0;
      for (int unsigned k = 0; k < NumWords; k++) begin
         for (int unsigned j = 0; j < SlotsPerWord; j++) begin
            r[k][32*j +: 32] = slot_val(k * SlotsPerWord + j);
         end
      end
      return r;
   endfunction

   localparam rom_t Rom = build_rom();

   if (RomSize < 2 || RomSize > 256) begin : g_bad_rom_size
      $error("boot_rom_obi: RomSize must be in 2..256");
   end
   if (DataWidth != 32 && DataWidth != 64) begin : g_bad_data_width
      $error("boot_rom_obi: DataWidth must be 32 or 64");
   end
   if (WaitCycles > 15) begin : g_bad_wait_cycles
      $error("boot_rom_obi: WaitCycles must be in 0..15");
   end
   if (EndAddr > 33'h1_0000_0000) begin : g_bad_addr_range
      $error("boot_rom_obi: BaseAddr + ROM size overflows 32 bits");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic            err_q, err_d;

   logic        in_range;
   logic        acc_err;
   logic [31:0] offset;
   logic [31:0] word_off;

   assign in_range = (addr_i >= BaseAddr) && ({1'b0, addr_i} < EndAddr);
   assign acc_err  = we_i || !in_range;
   assign offset   = addr_i - BaseAddr;
   assign word_off = offset >> ByteShift;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      err_d    = err_q;
      gnt_o    = 1'b0;
      rvalid_o = 1'b0;
      rdata_o  = '0;
      err_o    = 1'b0;
      if (!rst_i) begin
         case (state_q)
            IDLE: begin
               gnt_o = req_i;
               if (req_i) begin
                  err_d = acc_err;
                  idx_d = acc_err ? '0 : word_off[IdxW-1:0];
                  if (WaitCycles == 0) begin
                     state_d = RESP;
                  end else begin
                     state_d = WAIT;
                     cnt_d   = 4'(WaitCycles - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_d = RESP;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            RESP: begin
               rvalid_o = 1'b1;
               err_o    = err_q;
               rdata_o  = err_q ? '0 : Rom[idx_q];
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

endmodule
`default_nettype wire
